// File: rtl/hilo_div_unit_if.sv
// HI/LO divider pipeline-facing bundle: divide request, mthi/mtlo, mfhi/mflo
// hazard and result/status returns.
interface hilo_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             signed_op;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             hilo_rd;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic             stall;

    modport master (
        output start,
        output signed_op,
        output dividend,
        output divisor,
        output hilo_rd,
        output hi_we,
        output lo_we,
        output wdata,
        input  hi,
        input  lo,
        input  busy,
        input  done,
        input  div_by_zero,
        input  stall
    );

    modport slave (
        input  start,
        input  signed_op,
        input  dividend,
        input  divisor,
        input  hilo_rd,
        input  hi_we,
        input  lo_we,
        input  wdata,
        output hi,
        output lo,
        output busy,
        output done,
        output div_by_zero,
        output stall
    );
endinterface

// File: rtl/hilo_div_unit.sv
// Iterative restoring divider owning HI/LO; one quotient bit per cycle.
// Define HILO_DIV_SIGNED_EN to honour signed_op (div); otherwise all divu.
module hilo_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input logic            clk,
    input logic            rst,
    hilo_div_unit_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dsr;
    logic [CNT_W-1:0] cnt;
    logic             dz;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic             busy_r;
    logic             done_r;
    logic             dbz_r;

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] rem_sub;
    logic             take;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    // Guard bit keeps the shifted remainder compare exact before subtracting.
    assign rem_sh  = {rem, dvd[WIDTH-1]};
    assign take    = rem_sh >= {1'b0, dsr};
    assign rem_sub = rem_sh[WIDTH-1:0] - dsr;

`ifdef HILO_DIV_SIGNED_EN
    logic sgn_a;
    logic sgn_b;
    logic neg_q;
    logic neg_r;

    assign sgn_a = bus.signed_op & bus.dividend[WIDTH-1];
    assign sgn_b = bus.signed_op & bus.divisor[WIDTH-1];
    assign mag_a = sgn_a ? -bus.dividend : bus.dividend;
    assign mag_b = sgn_b ? -bus.divisor : bus.divisor;
    assign q_fix = neg_q ? -dvd : dvd;
    assign r_fix = neg_r ? -rem : rem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (state == IDLE && bus.start) begin
            neg_q <= sgn_a ^ sgn_b;
            neg_r <= sgn_a;
        end
    end
`else
    assign mag_a = bus.dividend;
    assign mag_b = bus.divisor;
    assign q_fix = dvd;
    assign r_fix = rem;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            rem    <= '0;
            dvd    <= '0;
            dsr    <= '0;
            cnt    <= '0;
            dz     <= 1'b0;
            hi_r   <= '0;
            lo_r   <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            dbz_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.hi_we) hi_r <= bus.wdata;
                    if (bus.lo_we) lo_r <= bus.wdata;
                    if (bus.start) begin
                        rem    <= '0;
                        dvd    <= mag_a;
                        dsr    <= mag_b;
                        dz     <= (bus.divisor == '0);
                        cnt    <= CNT_W'(WIDTH);
                        busy_r <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    rem <= take ? rem_sub : rem_sh[WIDTH-1:0];
                    dvd <= {dvd[WIDTH-2:0], take};
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) state <= FIX;
                end
                FIX: begin
                    // Zero divisor leaves |dividend| in rem; quotient forced to ones.
                    hi_r   <= r_fix;
                    lo_r   <= dz ? '1 : q_fix;
                    dbz_r  <= dz;
                    done_r <= 1'b1;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.hi          = hi_r;
    assign bus.lo          = lo_r;
    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.div_by_zero = dbz_r;
    assign bus.stall       = busy_r & (bus.hilo_rd | bus.hi_we | bus.lo_we);

endmodule

// File: tb/tb_hilo_div_unit.sv
// Scoreboard bench for hilo_div_unit: directed divides, HI/LO hazards,
// start-while-busy and mid-divide reset.
module tb_hilo_div_unit;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hilo_div_unit_if #(.WIDTH(W)) bus ();

    hilo_div_unit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           id;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   vectors    = 0;
    int   miscompares = 0;
    int   done_cnt   = 0;
    int   next_id    = 0;

    task automatic chk(input string nm, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus.done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_done: got lo %h hi %h expected none",
                         bus.lo, bus.hi);
            end else begin
                mon_e = exp_q.pop_front();
                chk($sformatf("v%0d_lo", mon_e.id), bus.lo, mon_e.lo);
                chk($sformatf("v%0d_hi", mon_e.id), bus.hi, mon_e.hi);
                chk($sformatf("v%0d_dbz", mon_e.id),
                    {{(W-1){1'b0}}, bus.div_by_zero}, {{(W-1){1'b0}}, mon_e.dz});
            end
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input logic [W-1:0] ehi,
                         input logic [W-1:0] elo, input logic edz);
        exp_t e;
        e.hi = ehi;
        e.lo = elo;
        e.dz = edz;
        e.id = next_id;
        next_id++;
        exp_q.push_back(e);
        bus.dividend  = a;
        bus.divisor   = b;
        bus.signed_op = s;
        bus.start     = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int bc);
        lat = 0;
        bc  = 0;
        forever begin
            @(negedge clk);
            lat++;
            if (bus.busy) bc++;
            if (bus.done) break;
            if (lat > 100) begin
                vectors++;
                miscompares++;
                $display("FAIL done_timeout: got no done expected within 100");
                break;
            end
        end
    endtask

    int lat;
    int bc;
    int scnt;
    int d0;

    initial begin
        bus.start     = 1'b0;
        bus.signed_op = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.hilo_rd   = 1'b0;
        bus.hi_we     = 1'b0;
        bus.lo_we     = 1'b0;
        bus.wdata     = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bus.hilo_rd = 1'b1;
        #1;
        chk("rst_hi", bus.hi, 0);
        chk("rst_lo", bus.lo, 0);
        chk("rst_busy", W'(bus.busy), 0);
        chk("rst_done", W'(bus.done), 0);
        chk("rst_dbz", W'(bus.div_by_zero), 0);
        chk("idle_stall", W'(bus.stall), 0);
        bus.hilo_rd = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;

        issue(100, 7, 1'b0, 2, 14, 1'b0);
        wait_done(lat, bc);
        chk("divu_latency", lat, 34);
        chk("divu_busy_cycles", bc, 33);
        @(negedge clk);
        chk("done_one_cycle", W'(bus.done), 0);

`ifdef HILO_DIV_SIGNED_EN
        issue(32'hFFFF_FFF9, 2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        wait_done(lat, bc);
        issue(100, 32'hFFFF_FFF9, 1'b1, 2, 32'hFFFF_FFF2, 1'b0);
        wait_done(lat, bc);
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 32'h8000_0000, 1'b0);
        wait_done(lat, bc);
`else
        issue(32'hFFFF_FFF9, 2, 1'b1, 1, 32'h7FFF_FFFC, 1'b0);
        wait_done(lat, bc);
        issue(100, 32'hFFFF_FFF9, 1'b1, 100, 0, 1'b0);
        wait_done(lat, bc);
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 0, 1'b0);
        wait_done(lat, bc);
`endif
        issue(32'hFFFF_FFFF, 32'h0001_0000, 1'b0, 32'h0000_FFFF,
              32'h0000_FFFF, 1'b0);
        wait_done(lat, bc);

        issue(5, 0, 1'b0, 5, 32'hFFFF_FFFF, 1'b1);
        wait_done(lat, bc);
        chk("dz_latency", lat, 34);
        issue(9, 3, 1'b0, 0, 3, 1'b0);
        wait_done(lat, bc);
        chk("back_to_back_latency", lat, 34);
        issue(32'hFFFF_FFFB, 0, 1'b1, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1);
        wait_done(lat, bc);

        @(posedge clk);
        #1;
        bus.hi_we = 1'b1;
        bus.wdata = 32'h1234;
        issue(9, 3, 1'b0, 0, 3, 1'b0);
        bus.hi_we = 1'b0;
        #1 chk("mthi_with_start", bus.hi, 32'h1234);
        wait_done(lat, bc);

        issue(100, 7, 1'b0, 2, 14, 1'b0);
        repeat (4) @(posedge clk);
        #1 bus.hilo_rd = 1'b1;
        scnt = 0;
        lat  = 0;
        forever begin
            @(negedge clk);
            lat++;
            if (bus.done || lat > 100) break;
            if (bus.stall) scnt++;
        end
        chk("rd_stall_cycles", scnt, 29);
        chk("rd_stall_at_done", W'(bus.stall), 0);
        @(posedge clk);
        #1 bus.hilo_rd = 1'b0;

        issue(77, 8, 1'b0, 5, 9, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        bus.lo_we = 1'b1;
        bus.wdata = 32'hABCD;
        #1 chk("mtlo_busy_stall", W'(bus.stall), 1);
        wait_done(lat, bc);
        chk("mtlo_stall_release", W'(bus.stall), 0);
        @(posedge clk);
        #1 bus.lo_we = 1'b0;
        chk("mtlo_applied", bus.lo, 32'hABCD);
        chk("mtlo_hi_kept", bus.hi, 5);

        issue(100, 7, 1'b0, 2, 14, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        bus.dividend = 50;
        bus.divisor  = 5;
        bus.start    = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        d0 = done_cnt;
        wait_done(lat, bc);
        chk("busy_start_latency", lat, 24);
        repeat (40) @(negedge clk);
        chk("busy_start_one_done", done_cnt - d0, 1);

        @(posedge clk);
        #1;
        issue(200, 9, 1'b0, 2, 22, 1'b0);
        exp_q.delete();
        repeat (11) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_busy", W'(bus.busy), 0);
        chk("midrst_done", W'(bus.done), 0);
        chk("midrst_hi", bus.hi, 0);
        chk("midrst_lo", bus.lo, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        issue(1000, 10, 1'b0, 0, 100, 1'b0);
        wait_done(lat, bc);
        chk("post_rst_latency", lat, 34);

        repeat (3) @(posedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
